// File: rtl/sparce_sasa_engine_if.sv
// Pipeline-side signal bundle for the SPARCE skip engine.
// The pipeline is the master; the engine snoops through the slave modport.
interface sparce_sasa_engine_if;
   logic [31:0] pc;
   logic        if_ex_enable;
   logic        wb_en;
   logic [4:0]  rd;
   logic [31:0] wb_data;
   logic [31:0] rdata;
   logic        sasa_wen;
   logic [31:0] sasa_addr;
   logic [31:0] sasa_data;
   logic        sparce_en;
   logic        skipping;
   logic [31:0] sparce_target;

   modport master (
      output pc, if_ex_enable, wb_en, rd, wb_data, rdata,
      output sasa_wen, sasa_addr, sasa_data, sparce_en,
      input  skipping, sparce_target
   );

   modport slave (
      input  pc, if_ex_enable, wb_en, rd, wb_data, rdata,
      input  sasa_wen, sasa_addr, sasa_data, sparce_en,
      output skipping, sparce_target
   );
endinterface

// File: rtl/sparce_sasa_engine.sv
// SPARCE skip unit: direct-mapped SASA table plus register zero tracker.
// Emits a registered one-cycle skip pulse and redirect target on a qualified hit.
module sparce_sasa_engine #(
   parameter int          SASA_ENTRIES = 16,
   parameter logic [31:0] SASA_BASE    = 32'h0000_8000,
   parameter int          NREGS        = 32
) (
   input  logic                  CLK,
   input  logic                  nRST,
   sparce_sasa_engine_if.slave   sparce
);
   localparam int IDX_W = $clog2(SASA_ENTRIES);
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   typedef enum logic [1:0] {IDLE, SKIP, HOLD} state_t;

   logic [29:0]             trig_reg  [SASA_ENTRIES];
   logic [19:0]             off_reg   [SASA_ENTRIES];
   logic [4:0]              rs_a_reg  [SASA_ENTRIES];
   logic [4:0]              rs_b_reg  [SASA_ENTRIES];
   logic [SASA_ENTRIES-1:0] valid_reg;
   logic [SASA_ENTRIES-1:0] en_a_reg;
   logic [SASA_ENTRIES-1:0] en_b_reg;

   state_t      state_reg;
   logic        skipping_reg;
   logic [31:0] target_reg;

   logic [31:0]      zero_bits;
   logic             in_window;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] lk_idx;
   logic             za, zb, entry_match, hit, hold_exit;
   logic [31:0]      target_next;
   logic             unused_bits;

   // Table is aligned to its own size, so the window test is an upper-bit match.
   assign in_window = (sparce.sasa_addr[31:IDX_W+3] == SASA_BASE[31:IDX_W+3]);
   assign wr_idx    = sparce.sasa_addr[3 +: IDX_W];
   assign lk_idx    = sparce.pc[2 +: IDX_W];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_reg <= '0;
         en_a_reg  <= '0;
         en_b_reg  <= '0;
         for (int i = 0; i < SASA_ENTRIES; i++) begin
            trig_reg[i] <= '0;
            off_reg[i]  <= '0;
            rs_a_reg[i] <= '0;
            rs_b_reg[i] <= '0;
         end
      end else if (sparce.sasa_wen && in_window) begin
         if (!sparce.sasa_addr[2]) begin
            trig_reg[wr_idx]  <= sparce.sasa_data[31:2];
            valid_reg[wr_idx] <= sparce.sasa_data[0];
         end else begin
            off_reg[wr_idx]  <= sparce.sasa_data[19:0];
            rs_a_reg[wr_idx] <= sparce.sasa_data[24:20];
            rs_b_reg[wr_idx] <= sparce.sasa_data[29:25];
            en_a_reg[wr_idx] <= sparce.sasa_data[30];
            en_b_reg[wr_idx] <= sparce.sasa_data[31];
         end
      end
   end

   // Untracked registers (index >= NREGS) read as "not known zero".
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_zero
         if (gi == 0) begin : g_x0
            assign zero_bits[gi] = 1'b1;
         end else if (gi < NREGS) begin : g_trk
            logic zero_reg;
            always_ff @(posedge CLK or negedge nRST) begin
               if (!nRST)
                  zero_reg <= 1'b1;
               else if (sparce.wb_en && sparce.rd == 5'(gi))
                  zero_reg <= (sparce.wb_data == 32'h0);
            end
            assign zero_bits[gi] = zero_reg;
         end else begin : g_none
            assign zero_bits[gi] = 1'b0;
         end
      end
   endgenerate

   function automatic logic reg_zero(input logic [4:0] rs, input logic [31:0] zb_in,
                                     input logic wen, input logic [4:0] wrd,
                                     input logic [31:0] wdata);
      logic fwd;
      fwd = wen && (wrd == rs) && (rs != 5'd0) && ({1'b0, rs} < NREGS_L);
      return fwd ? (wdata == 32'h0) : zb_in[rs];
   endfunction

   always_comb begin
      za = reg_zero(rs_a_reg[lk_idx], zero_bits, sparce.wb_en, sparce.rd, sparce.wb_data);
      zb = reg_zero(rs_b_reg[lk_idx], zero_bits, sparce.wb_en, sparce.rd, sparce.wb_data);
      entry_match = valid_reg[lk_idx] && ({trig_reg[lk_idx], 2'b00} == sparce.pc);
      hit = sparce.sparce_en && sparce.if_ex_enable && entry_match
            && (!en_a_reg[lk_idx] || za) && (!en_b_reg[lk_idx] || zb);
      target_next = sparce.pc + {{10{off_reg[lk_idx][19]}}, off_reg[lk_idx], 2'b00};
      hold_exit = sparce.if_ex_enable && (sparce.pc == target_reg);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= IDLE;
         skipping_reg <= 1'b0;
         target_reg   <= 32'h0;
      end else if (!sparce.sparce_en) begin
         state_reg    <= IDLE;
         skipping_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (hit) begin
                  state_reg    <= SKIP;
                  skipping_reg <= 1'b1;
                  target_reg   <= target_next;
               end
            end
            SKIP: begin
               state_reg    <= HOLD;
               skipping_reg <= 1'b0;
            end
            HOLD: begin
               // Landing on the target may itself hit, chaining straight into another skip.
               if (hold_exit) begin
                  if (hit) begin
                     state_reg    <= SKIP;
                     skipping_reg <= 1'b1;
                     target_reg   <= target_next;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: begin
               state_reg    <= IDLE;
               skipping_reg <= 1'b0;
            end
         endcase
      end
   end

   assign sparce.skipping      = skipping_reg;
   assign sparce.sparce_target = target_reg;

   assign unused_bits = ^{sparce.rdata, sparce.sasa_addr[1:0], sparce.sasa_data[1]};
endmodule

// File: tb/tb_sparce_sasa_engine.sv
// Directed bench for sparce_sasa_engine with hand-computed skip targets.
module tb_sparce_sasa_engine;
   logic CLK;
   logic nRST;
   int   n_checks = 0;
   int   n_pass   = 0;

   sparce_sasa_engine_if bus ();

   sparce_sasa_engine dut (
      .CLK    (CLK),
      .nRST   (nRST),
      .sparce (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s: got %08h", tag, got);
      end else begin
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.sasa_wen  = 1'b1;
      bus.sasa_addr = addr;
      bus.sasa_data = data;
      step();
      bus.sasa_wen = 1'b0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] data);
      bus.wb_en   = 1'b1;
      bus.rd      = r;
      bus.wb_data = data;
      step();
      bus.wb_en = 1'b0;
   endtask

   task automatic present(input logic [31:0] p);
      bus.pc           = p;
      bus.if_ex_enable = 1'b1;
      step();
      bus.if_ex_enable = 1'b0;
   endtask

   // After a pulse: confirm it lasted one cycle, then land on the target to leave HOLD.
   task automatic finish_skip(input string tag, input logic [31:0] tgt);
      step();
      check({tag, "_width"}, {31'd0, bus.skipping}, 32'd0);
      present(tgt);
   endtask

   initial begin
      nRST = 1'b0;
      bus.pc = 32'h0;
      bus.if_ex_enable = 1'b0;
      bus.wb_en = 1'b0;
      bus.rd = 5'd0;
      bus.wb_data = 32'h0;
      bus.rdata = 32'h0;
      bus.sasa_wen = 1'b0;
      bus.sasa_addr = 32'h0;
      bus.sasa_data = 32'h0;
      bus.sparce_en = 1'b1;
      step();
      step();
      check("rst_skipping", {31'd0, bus.skipping}, 32'd0);
      check("rst_target", bus.sparce_target, 32'h0);
      nRST = 1'b1;
      step();

      // Entry 3: trig 0x10C, conditional on x5, offset +4 words
      wr(32'h0000_8018, 32'h0000_010D);
      wr(32'h0000_801C, 32'h4050_0004);
      wb(5'd5, 32'h0);
      present(32'h0000_010C);
      check("basic_skip", {31'd0, bus.skipping}, 32'd1);
      check("basic_target", bus.sparce_target, 32'h0000_011C);
      step();
      check("basic_width", {31'd0, bus.skipping}, 32'd0);

      // HOLD suppresses repeated lookups of the trigger
      present(32'h0000_010C);
      check("hold_no_repulse", {31'd0, bus.skipping}, 32'd0);
      check("hold_target_kept", bus.sparce_target, 32'h0000_011C);
      present(32'h0000_011C);
      check("hold_exit", {31'd0, bus.skipping}, 32'd0);
      present(32'h0000_010C);
      check("reskip", {31'd0, bus.skipping}, 32'd1);
      finish_skip("reskip", 32'h0000_011C);

      // Non-zero source blocks; same-cycle zero writeback is forwarded
      wb(5'd5, 32'h1);
      present(32'h0000_010C);
      check("nz_noskip", {31'd0, bus.skipping}, 32'd0);
      bus.wb_en = 1'b1;
      bus.rd = 5'd5;
      bus.wb_data = 32'h0;
      present(32'h0000_010C);
      bus.wb_en = 1'b0;
      check("fwd_skip", {31'd0, bus.skipping}, 32'd1);
      check("fwd_target", bus.sparce_target, 32'h0000_011C);
      finish_skip("fwd", 32'h0000_011C);

      // Negative offset and wrap-around targets, unconditional entries
      wr(32'h0000_8000, 32'h0000_0201);
      wr(32'h0000_8004, 32'h000F_FFFE);
      present(32'h0000_0200);
      check("neg_target", bus.sparce_target, 32'h0000_01F8);
      finish_skip("neg", 32'h0000_01F8);
      wr(32'h0000_8078, 32'hFFFF_FFFD);
      wr(32'h0000_807C, 32'h0000_0001);
      present(32'hFFFF_FFFC);
      check("wrap_skip", {31'd0, bus.skipping}, 32'd1);
      check("wrap_target", bus.sparce_target, 32'h0000_0000);
      finish_skip("wrap", 32'h0000_0000);

      // Out-of-window writes (just above and just below) must not clobber entries 0 and 15
      wr(32'h0000_8080, 32'h0000_0000);
      wr(32'h0000_7FF8, 32'h0000_0000);
      present(32'h0000_0200);
      check("oow_above", {31'd0, bus.skipping}, 32'd1);
      finish_skip("oow_above", 32'h0000_01F8);
      present(32'hFFFF_FFFC);
      check("oow_below", {31'd0, bus.skipping}, 32'd1);
      finish_skip("oow_below", 32'h0000_0000);

      // Invalid entry never skips
      wr(32'h0000_8010, 32'h0000_0108);
      wr(32'h0000_8014, 32'h0000_0000);
      present(32'h0000_0108);
      check("invalid_noskip", {31'd0, bus.skipping}, 32'd0);

      // Global disable blocks an otherwise qualifying hit
      bus.sparce_en = 1'b0;
      present(32'h0000_010C);
      check("disabled_noskip", {31'd0, bus.skipping}, 32'd0);
      bus.sparce_en = 1'b1;
      step();

      // Async reset during SKIP clears the pulse at once and empties the table
      present(32'h0000_010C);
      check("pre_reset_skip", {31'd0, bus.skipping}, 32'd1);
      nRST = 1'b0;
      #1;
      check("async_rst_skipping", {31'd0, bus.skipping}, 32'd0);
      check("async_rst_target", bus.sparce_target, 32'h0);
      step();
      nRST = 1'b1;
      step();
      present(32'h0000_010C);
      check("post_reset_noskip", {31'd0, bus.skipping}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/sparce_sasa_engine.md
Name: sparce_sasa_engine

Overview:
- Next-generation SPARCE skip unit. Parametrised, direct-mapped SASA (sparsity-aware skip address) table plus per-register zero tracker.
- Snoops fetch PC and writeback. Asserts a one-cycle skip with a redirect target when a table entry's trigger PC matches and all enabled source-register conditions are zero.
- Sits beside the pipeline on the sparce modport signals.

Parameters:
SASA_ENTRIES, 16, table depth; power of two, 2..256; IDX_W = log2(SASA_ENTRIES)
SASA_BASE, 32'h0000_8000, byte base of the table's write window; aligned to 8*SASA_ENTRIES
NREGS, 32, architectural registers tracked; x0 is hardwired zero

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
pc  in  32  current fetch PC
if_ex_enable  in  1  pipeline advancing this cycle; lookups qualify on it
wb_en  in  1  register writeback valid
rd  in  5  writeback destination
wb_data  in  32  writeback value
rdata  in  32  ignored (reserved)
sasa_wen  in  1  table write strobe
sasa_addr  in  32  table write byte address
sasa_data  in  32  table write data
sparce_en  in  1  global enable; 0 forces IDLE and blocks skips
skipping  out  1  one-cycle skip pulse (registered)
sparce_target  out  32  redirect PC, valid while skipping (registered)

Behaviour:
- Reset (async, nRST=0): all entries invalid, zero[] all 1, FSM=IDLE, skipping=0, sparce_target=0.
- Write window: SASA_BASE <= sasa_addr < SASA_BASE + 8*SASA_ENTRIES. Writes outside it are ignored.
  - idx = sasa_addr[3 +: IDX_W]; word select = sasa_addr[2].
  - Word 0: trig_pc = {sasa_data[31:2], 2'b00}; valid = sasa_data[0].
  - Word 1: offset = sasa_data[19:0], signed, in words; rs_a = [24:20]; rs_b = [29:25]; en_a = [30]; en_b = [31].
  - Writes take effect the next cycle. A same-cycle lookup of the same entry sees the old contents.
- Zero tracker: on wb_en with rd != 0, zero[rd] <= (wb_data == 32'h0). zero[0] is constant 1. rd >= NREGS is ignored.
- Condition evaluation forwards a same-cycle writeback: if wb_en && rd == rs, use (wb_data == 0) instead of the stored bit.
- Lookup (combinational): e = table[pc[2 +: IDX_W]].
  - hit = sparce_en && if_ex_enable && e.valid && e.trig_pc == pc && (!en_a || z(rs_a)) && (!en_b || z(rs_b)).
  - Both enables 0 means an unconditional skip.
- FSM:
  - IDLE: on hit -> SKIP; skipping <= 1; sparce_target <= pc + sign_extend(offset << 2), mod 2^32.
  - SKIP (1 cycle): skipping <= 0 -> HOLD.
  - HOLD: hits suppressed. Exit to IDLE when if_ex_enable && pc == sparce_target, or when sparce_en=0. The target-PC lookup is evaluated in the same cycle as the exit and may itself hit (chained skip -> SKIP).
- Latency: skipping rises the cycle after the qualifying if_ex_enable edge; width is exactly 1 cycle.
- sparce_target holds its last value outside SKIP.
- Zero tracker keeps updating in every state.
- sparce_en=0 in any state: next state IDLE, skipping <= 0.
- Offset wrap: address arithmetic wraps mod 2^32. Offset 0 gives target == pc; HOLD then exits on the next qualifying cycle at that pc.
- Reset mid-SKIP/HOLD: immediate IDLE, skipping=0; table contents lost.

Test Plan:
- Reset, then write entry 3: word0 = 0x0000_010D, word1 = 0x4050_0004 (en_a=1, rs_a=5, offset=4). wb x5=0. pc=0x10C with if_ex_enable -> next cycle skipping=1, sparce_target=0x11C; following cycle skipping=0.
- Same entry, wb x5=0x1 -> pc=0x10C gives no skip. Then wb x5=0 in the same cycle as the pc=0x10C lookup -> forwarding yields skip, target 0x11C.
- Offset 0xFFFFE (-2 words) at trig_pc 0x200 -> sparce_target=0x1F8. Offset 1 at trig_pc 0xFFFF_FFFC -> target 0x0 (wrap).
- In HOLD, re-present pc=0x10C -> no second pulse. Present pc=0x11C with if_ex_enable -> FSM returns to IDLE; a later pc=0x10C skips again.
- Write at SASA_BASE + 8*SASA_ENTRIES -> ignored. Entry with valid=0 -> never skips. sparce_en=0 during a hit -> no skip.
- Assert nRST low during SKIP -> skipping=0 immediately, all entries invalid, and a subsequent pc=0x10C does not skip.
